// File: rtl/gpu_scan_pkg.sv
// Shared types and step-size helpers for the autonomous primitive scanner.
package gpu_scan_pkg;

    typedef enum logic {
        SCAN_RECT = 1'b0,
        SCAN_TRI  = 1'b1
    } scanMode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } scanState_t;

    localparam int MAX_STEP_LOG2 = 4;

    // Horizontal pixels covered by one scan step.
    function automatic int step_size(input int step_log2);
        return 1 << step_log2;
    endfunction

    // Low-bit mask (ones) that must be cleared to step-align an X coordinate.
    function automatic int align_bits(input int step_log2);
        return (1 << step_log2) - 1;
    endfunction

endpackage

// File: rtl/gpu_scan_xstep.sv
// Combinational X stepper: aligned span, next X in the current direction,
// and whether that next X still lies inside the aligned span.
module gpu_scan_xstep
    import gpu_scan_pkg::*;
#(
    parameter int COORD_W   = 12,
    parameter int STEP_LOG2 = 1
) (
    input  logic signed [COORD_W-1:0] i_x,
    input  logic signed [COORD_W-1:0] i_xMin,
    input  logic signed [COORD_W-1:0] i_xMax,
    input  logic                      i_dir,
    output logic signed [COORD_W:0]   o_xS,
    output logic signed [COORD_W:0]   o_xE,
    output logic signed [COORD_W:0]   o_nx,
    output logic                      o_inside
);

    localparam logic signed [COORD_W:0] STEP_W     = (COORD_W+1)'(step_size(STEP_LOG2));
    localparam logic        [COORD_W:0] ALIGN_MASK = ~((COORD_W+1)'(align_bits(STEP_LOG2)));

    logic signed [COORD_W:0] x_ext;

    always_comb begin
        x_ext    = {i_x[COORD_W-1], i_x};
        o_xS     = {i_xMin[COORD_W-1], i_xMin} & ALIGN_MASK;
        o_xE     = {i_xMax[COORD_W-1], i_xMax} & ALIGN_MASK;
        // One extra bit keeps a step past either bound from wrapping back inside.
        o_nx     = i_dir ? (x_ext - STEP_W) : (x_ext + STEP_W);
        o_inside = (o_nx >= o_xS) && (o_nx <= o_xE);
    end

endmodule

// File: rtl/gpu_scan_gen.sv
// Self-stepping bounding-box scanner: raster order for rectangles, serpentine
// with coverage feedback for triangles, one coordinate per valid/ready beat.
module gpu_scan_gen
    import gpu_scan_pkg::*;
#(
    parameter int COORD_W   = 12,
    parameter int STEP_LOG2 = 1
) (
    input  logic                      i_clk,
    input  logic                      i_nRst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic                      i_mode,
    input  logic                      i_interlace,
    input  logic                      i_field,
    input  logic signed [COORD_W-1:0] i_xMin,
    input  logic signed [COORD_W-1:0] i_xMax,
    input  logic signed [COORD_W-1:0] i_yMin,
    input  logic signed [COORD_W-1:0] i_yMax,
    output logic                      o_busy,
    output logic                      o_valid,
    input  logic                      i_ready,
    input  logic                      i_hit,
    output logic signed [COORD_W-1:0] o_pixelX,
    output logic signed [COORD_W-1:0] o_pixelY,
    output logic                      o_dir,
    output logic                      o_lastLine,
    output logic                      o_done
);

    scanState_t              state_q;
    scanMode_t               mode_q;
    logic                    interlace_q;
    logic                    field_q;
    logic signed [COORD_W-1:0] xmin_q;
    logic signed [COORD_W-1:0] xmax_q;
    logic signed [COORD_W-1:0] ymin_q;
    logic signed [COORD_W-1:0] ymax_q;
    logic signed [COORD_W-1:0] x_q;
    logic signed [COORD_W-1:0] y_q;
    logic                    dir_q;
    logic                    found_q;
    logic                    complete_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    last_q;

    logic signed [COORD_W:0] xs;
    logic signed [COORD_W:0] xe;
    logic signed [COORD_W:0] nx;
    logic                    nx_inside;

    logic signed [COORD_W:0] ymin_ext;
    logic signed [COORD_W:0] ymax_ext;
    logic signed [COORD_W:0] y_ext;
    logic signed [COORD_W:0] ystep;
    logic signed [COORD_W:0] ys;
    logic signed [COORD_W:0] ny;
    logic                    ys_last;
    logic                    ny_last;
    logic                    y_last;
    logic                    accept;
    logic                    line_end;

    gpu_scan_xstep #(
        .COORD_W   (COORD_W),
        .STEP_LOG2 (STEP_LOG2)
    ) u_xstep (
        .i_x      (x_q),
        .i_xMin   (xmin_q),
        .i_xMax   (xmax_q),
        .i_dir    (dir_q),
        .o_xS     (xs),
        .o_xE     (xe),
        .o_nx     (nx),
        .o_inside (nx_inside)
    );

    always_comb begin
        ymin_ext = {ymin_q[COORD_W-1], ymin_q};
        ymax_ext = {ymax_q[COORD_W-1], ymax_q};
        y_ext    = {y_q[COORD_W-1], y_q};
        ystep    = interlace_q ? (COORD_W+1)'(2) : (COORD_W+1)'(1);
        // Interlaced scans start on the first line belonging to the current field.
        ys       = ymin_ext + (interlace_q ? {{COORD_W{1'b0}}, ymin_q[0] ^ field_q}
                                           : {(COORD_W+1){1'b0}});
        ny       = y_ext + ystep;
        ys_last  = (ys + ystep) > ymax_ext;
        ny_last  = (ny + ystep) > ymax_ext;
        y_last   = ny > ymax_ext;
        accept   = valid_q && i_ready;
        line_end = (i_hit && !nx_inside)
                || (!i_hit && found_q)
                || (!i_hit && !found_q && !nx_inside && complete_q);
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q     <= IDLE;
            mode_q      <= SCAN_RECT;
            interlace_q <= 1'b0;
            field_q     <= 1'b0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            dir_q       <= 1'b0;
            found_q     <= 1'b0;
            complete_q  <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_abort) begin
                state_q    <= IDLE;
                valid_q    <= 1'b0;
                busy_q     <= 1'b0;
                found_q    <= 1'b0;
                complete_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            state_q     <= INIT;
                            busy_q      <= 1'b1;
                            mode_q      <= scanMode_t'(i_mode);
                            interlace_q <= i_interlace;
                            field_q     <= i_field;
                            xmin_q      <= i_xMin;
                            xmax_q      <= i_xMax;
                            ymin_q      <= i_yMin;
                            ymax_q      <= i_yMax;
                        end
                    end
                    INIT: begin
                        if ((xmin_q > xmax_q) || (ys > ymax_ext)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= SCAN;
                            valid_q    <= 1'b1;
                            x_q        <= xs[COORD_W-1:0];
                            y_q        <= ys[COORD_W-1:0];
                            dir_q      <= 1'b0;
                            found_q    <= 1'b0;
                            complete_q <= 1'b0;
                            last_q     <= ys_last;
                        end
                    end
                    SCAN: begin
                        if (accept) begin
                            if (mode_q == SCAN_RECT) begin
                                if (nx_inside) begin
                                    x_q <= nx[COORD_W-1:0];
                                end else if (!y_last) begin
                                    x_q    <= xs[COORD_W-1:0];
                                    y_q    <= ny[COORD_W-1:0];
                                    last_q <= ny_last;
                                end else begin
                                    state_q <= DONE;
                                    valid_q <= 1'b0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else if (i_hit && nx_inside) begin
                                found_q <= 1'b1;
                                x_q     <= nx[COORD_W-1:0];
                            end else if (line_end) begin
                                if (y_last) begin
                                    state_q <= DONE;
                                    valid_q <= 1'b0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    y_q        <= ny[COORD_W-1:0];
                                    last_q     <= ny_last;
                                    dir_q      <= ~dir_q;
                                    found_q    <= 1'b0;
                                    complete_q <= 1'b0;
                                end
                            end else if (!found_q && !nx_inside) begin
                                // Missed the whole way to an edge: turn round and
                                // re-emit this X so the far side of the line is covered.
                                dir_q      <= ~dir_q;
                                complete_q <= 1'b1;
                            end else begin
                                x_q <= nx[COORD_W-1:0];
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_valid    = valid_q;
    assign o_pixelX   = x_q;
    assign o_pixelY   = y_q;
    assign o_dir      = dir_q;
    assign o_lastLine = last_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_gpu_scan_gen.sv
// Directed bench for gpu_scan_gen: raster, interlace, serpentine, stall,
// degenerate box and abort sequences with hand-computed beats.
module tb_gpu_scan_gen;

    localparam int CW = 12;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          mode;
    logic          interlace;
    logic          field;
    logic [CW-1:0] xmin, xmax, ymin, ymax;
    logic          busy, valid, ready, hit, dir, last_line, done;
    logic [CW-1:0] px, py;

    int checks   = 0;
    int failures = 0;

    gpu_scan_gen #(.COORD_W(CW), .STEP_LOG2(1)) dut (
        .i_clk       (clk),
        .i_nRst      (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_mode      (mode),
        .i_interlace (interlace),
        .i_field     (field),
        .i_xMin      (xmin),
        .i_xMax      (xmax),
        .i_yMin      (ymin),
        .i_yMax      (ymax),
        .o_busy      (busy),
        .o_valid     (valid),
        .i_ready     (ready),
        .i_hit       (hit),
        .o_pixelX    (px),
        .o_pixelY    (py),
        .o_dir       (dir),
        .o_lastLine  (last_line),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge after the start edge (INIT).
    task automatic start_scan(input logic m, input logic il, input logic fld,
                              input int x0, input int x1, input int y0, input int y1);
        mode      = m;
        interlace = il;
        field     = fld;
        xmin      = CW'(x0);
        xmax      = CW'(x1);
        ymin      = CW'(y0);
        ymax      = CW'(y1);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Check the presented beat, give it a coverage bit, let it be accepted.
    task automatic beat(input string tag, input int x, input int y,
                        input logic d, input logic l, input logic h);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".x"}, 32'(px), 32'(CW'(x)));
        chk({tag, ".y"}, 32'(py), 32'(CW'(y)));
        chk({tag, ".dir"}, 32'(dir), 32'(d));
        chk({tag, ".last"}, 32'(last_line), 32'(l));
        $display("beat %s x=%0d y=%0d dir=%0d last=%0d hit=%0d", tag, px, py, dir, last_line, h);
        hit = h;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        $display("done %s", tag);
    endtask

    task automatic expect_init(input string tag);
        chk({tag, ".init_valid"}, 32'(valid), 32'd0);
        chk({tag, ".init_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        interlace = 1'b0; field = 1'b0; ready = 1'b0; hit = 1'b0;
        xmin = '0; xmax = '0; ymin = '0; ymax = '0;

        // Reset state
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.dir", 32'(dir), 32'd0);
        chk("rst.x", 32'(px), 32'd0);
        chk("rst.y", 32'(py), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);

        // RECT X 1..6 Y 0..1: xS=0, xE=6
        start_scan(1'b0, 1'b0, 1'b0, 1, 6, 0, 1);
        expect_init("rect");
        beat("rect0", 0, 0, 1'b0, 1'b0, 1'b0);
        beat("rect1", 2, 0, 1'b0, 1'b0, 1'b0);
        beat("rect2", 4, 0, 1'b0, 1'b0, 1'b0);
        beat("rect3", 6, 0, 1'b0, 1'b0, 1'b0);
        beat("rect4", 0, 1, 1'b0, 1'b1, 1'b0);
        beat("rect5", 2, 1, 1'b0, 1'b1, 1'b0);
        beat("rect6", 4, 1, 1'b0, 1'b1, 1'b0);
        beat("rect7", 6, 1, 1'b0, 1'b1, 1'b0);
        expect_done("rect");

        // Interlaced, field 1, Y 4..9: lines 5,7,9
        start_scan(1'b0, 1'b1, 1'b1, 0, 1, 4, 9);
        expect_init("ilace");
        beat("ilace0", 0, 5, 1'b0, 1'b0, 1'b0);
        beat("ilace1", 0, 7, 1'b0, 1'b0, 1'b0);
        beat("ilace2", 0, 9, 1'b0, 1'b1, 1'b0);
        expect_done("ilace");

        // Triangle serpentine, X 0..6 Y 0..1
        start_scan(1'b1, 1'b0, 1'b0, 0, 6, 0, 1);
        expect_init("tri");
        beat("tri0", 0, 0, 1'b0, 1'b0, 1'b1);
        beat("tri1", 2, 0, 1'b0, 1'b0, 1'b1);
        beat("tri2", 4, 0, 1'b0, 1'b0, 1'b0);
        beat("tri3", 4, 1, 1'b1, 1'b1, 1'b0);
        beat("tri4", 2, 1, 1'b1, 1'b1, 1'b0);
        beat("tri5", 0, 1, 1'b1, 1'b1, 1'b0);
        beat("tri6", 0, 1, 1'b0, 1'b1, 1'b0);
        beat("tri7", 2, 1, 1'b0, 1'b1, 1'b0);
        beat("tri8", 4, 1, 1'b0, 1'b1, 1'b0);
        beat("tri9", 6, 1, 1'b0, 1'b1, 1'b0);
        expect_done("tri");

        // Stall: ready low for 5 cycles while (4,0) is presented
        start_scan(1'b0, 1'b0, 1'b0, 0, 6, 0, 0);
        expect_init("stall");
        beat("stall0", 0, 0, 1'b0, 1'b1, 1'b0);
        beat("stall1", 2, 0, 1'b0, 1'b1, 1'b0);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall.hold_valid", 32'(valid), 32'd1);
            chk("stall.hold_x", 32'(px), 32'd4);
            chk("stall.hold_y", 32'(py), 32'd0);
            chk("stall.hold_dir", 32'(dir), 32'd0);
            $display("stall cycle %0d x=%0d y=%0d", i, px, py);
        end
        ready = 1'b1;
        beat("stall2", 4, 0, 1'b0, 1'b1, 1'b0);
        beat("stall3", 6, 0, 1'b0, 1'b1, 1'b0);
        expect_done("stall");

        // Degenerate box: done exactly two cycles after the start edge
        start_scan(1'b0, 1'b0, 1'b0, 8, 3, 0, 0);
        chk("degen.c1_valid", 32'(valid), 32'd0);
        chk("degen.c1_done", 32'(done), 32'd0);
        @(negedge clk);
        expect_done("degen");

        // Abort with a coincident start while presenting the fourth beat
        start_scan(1'b0, 1'b0, 1'b0, 0, 6, 0, 1);
        expect_init("abort");
        beat("abort0", 0, 0, 1'b0, 1'b0, 1'b0);
        beat("abort1", 2, 0, 1'b0, 1'b0, 1'b0);
        beat("abort2", 4, 0, 1'b0, 1'b0, 1'b0);
        chk("abort.pre_x", 32'(px), 32'd6);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort.valid", 32'(valid), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort.idle_busy", 32'(busy), 32'd0);
        chk("abort.idle_done", 32'(done), 32'd0);
        chk("abort.idle_valid", 32'(valid), 32'd0);
        $display("abort handled");

        // Fresh start after abort: X 2..3 Y 1..1 is a single beat
        start_scan(1'b0, 1'b0, 1'b0, 2, 3, 1, 1);
        expect_init("restart");
        beat("restart0", 2, 1, 1'b0, 1'b1, 1'b0);
        expect_done("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
